// File: rtl/paper_systolic_controller.sv
// Sequencer for a DIM x DIM output-stationary systolic multiplier: clears the PEs,
// streams K skewed operand wavefronts, then drains one result row per accepted cycle.
module paper_systolic_controller #(
   parameter int DIM   = 4,
   parameter int LEN_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [LEN_W-1:0]         kLen,
   input  logic                     outReady,
   output logic                     busy,
   output logic                     peClear,
   output logic                     enableMul,
   output logic                     enableShiftOut,
   output logic [DIM-1:0]           feedValid,
   output logic [LEN_W:0]           feedK,
   output logic                     outValid,
   output logic [$clog2(DIM)-1:0]   outRow,
   output logic                     done,
   output logic [2:0]               dbg_state_o
);

   localparam int ROW_W = $clog2(DIM);
   localparam logic [LEN_W:0] SKEW    = (LEN_W+1)'(2 * (DIM - 1));
   localparam logic [LEN_W:0] T_ONE   = (LEN_W+1)'(1);
   localparam logic [ROW_W-1:0] R_LAST = ROW_W'(DIM - 1);
   localparam logic [ROW_W-1:0] R_ONE  = ROW_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MUL   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q;
   logic [LEN_W-1:0] k_q;
   logic [LEN_W:0]   t_q;
   logic [ROW_W-1:0] r_q;

   logic [LEN_W:0]   k_ext;
   logic [LEN_W:0]   t_last;
   logic             in_mul;
   logic             in_shift;

   // Last MUL index is K + 2*(DIM-1) - 1; one extra bit keeps it from wrapping at max K.
   assign k_ext  = {1'b0, k_q};
   assign t_last = k_ext + SKEW - T_ONE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         t_q     <= '0;
         r_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  k_q     <= kLen;
                  t_q     <= '0;
                  r_q     <= '0;
                  state_q <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               state_q <= (k_q != '0) ? S_MUL : S_SHIFT;
            end
            S_MUL: begin
               if (t_q == t_last) begin
                  state_q <= S_SHIFT;
               end else begin
                  t_q <= t_q + T_ONE;
               end
            end
            S_SHIFT: begin
               // A row only leaves when the consumer takes it, so r and the array freeze on stalls.
               if (outReady) begin
                  if (r_q == R_LAST) begin
                     state_q <= S_DONE;
                  end else begin
                     r_q <= r_q + R_ONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_mul   = (state_q == S_MUL);
   assign in_shift = (state_q == S_SHIFT);

   assign busy           = (state_q != S_IDLE);
   assign peClear        = (state_q == S_CLEAR);
   assign enableMul      = in_mul;
   assign enableShiftOut = in_shift & outReady;
   assign outValid       = in_shift & outReady;
   assign done           = (state_q == S_DONE);
   assign feedK          = in_mul ? t_q : '0;
   assign outRow         = in_shift ? r_q : '0;
   assign dbg_state_o    = state_q;

   // Row/column g is skewed by g cycles, so its K operands arrive during t = g .. g+K-1.
   for (genvar g = 0; g < DIM; g++) begin : g_feed
      localparam logic [LEN_W:0] IDX = (LEN_W+1)'(g);
      assign feedValid[g] = in_mul && (t_q >= IDX) && (t_q < IDX + k_ext);
   end

endmodule

// File: tb/tb_paper_systolic_controller.sv
// Bench for paper_systolic_controller: per-job phase model drives inputs and checks
// control outputs each cycle; a queue of expected result rows is drained by a monitor.
module tb_paper_systolic_controller;

   localparam int DIM   = 4;
   localparam int LEN_W = 16;
   localparam int RW    = $clog2(DIM);
   localparam int W     = 8;
   localparam logic [W-1:0] DONE_TOK = 8'h80;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [LEN_W-1:0] kLen;
   logic             outReady;
   logic             busy, peClear, enableMul, enableShiftOut, outValid, done;
   logic [DIM-1:0]   feedValid;
   logic [LEN_W:0]   feedK;
   logic [RW-1:0]    outRow;
   logic [2:0]       dbg_state;

   // Small instance for the maximum-length run.
   logic             s_start, s_outReady;
   logic [7:0]       s_kLen;
   logic             s_busy, s_peClear, s_mul, s_shift, s_outValid, s_done;
   logic [1:0]       s_feedValid;
   logic [8:0]       s_feedK;
   logic [0:0]       s_outRow;
   logic [2:0]       s_dbg;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   paper_systolic_controller #(.DIM(DIM), .LEN_W(LEN_W)) dut (
      .clock(clock), .reset(reset), .start(start), .kLen(kLen), .outReady(outReady),
      .busy(busy), .peClear(peClear), .enableMul(enableMul), .enableShiftOut(enableShiftOut),
      .feedValid(feedValid), .feedK(feedK), .outValid(outValid), .outRow(outRow),
      .done(done), .dbg_state_o(dbg_state)
   );

   paper_systolic_controller #(.DIM(2), .LEN_W(8)) dut_small (
      .clock(clock), .reset(reset), .start(s_start), .kLen(s_kLen), .outReady(s_outReady),
      .busy(s_busy), .peClear(s_peClear), .enableMul(s_mul), .enableShiftOut(s_shift),
      .feedValid(s_feedValid), .feedK(s_feedK), .outValid(s_outValid), .outRow(s_outRow),
      .done(s_done), .dbg_state_o(s_dbg)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {busy, peClear, enableMul, enableShiftOut, outValid, done, feedValid, feedK, outRow},
            64'd0);
   endtask

   task automatic pop_cmp(input string name, input logic [W-1:0] act);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: actual %0h required nothing (t=%0t)", name, act, $time);
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (outValid === 1'b1) pop_cmp("row_out", W'(outRow));
         if (done === 1'b1) pop_cmp("done_out", DONE_TOK);
      end
   end

   // ---------------- driver + phase model ----------------
   // Phases of a job counted in cycles after the accepting edge: cycle 1 clears,
   // cycles 2..1+M multiply (t = c-2), then rows drain on ready cycles, then one done cycle.
   task automatic run_job(input int k, input int rdy_pct, input int stall_at, input int stall_len,
                          input bit hold_start, input bit noise, input int rst_c);
      int m, rows, c, stalls_left, t;
      bit finished, rdy, in_mul, in_shift, is_done;
      logic [DIM-1:0] e_fv;
      m = (k == 0) ? 0 : k + 2 * (DIM - 1);
      stalls_left = stall_len;
      if (rst_c == 0) begin
         for (int i = 0; i < DIM; i++) exp_q.push_back(W'(i));
         exp_q.push_back(DONE_TOK);
      end
      start = 1'b1;
      kLen  = LEN_W'(k);
      @(posedge clock); #1;
      if (!hold_start) start = 1'b0;
      rows = 0;
      c = 1;
      finished = 1'b0;
      while (!finished) begin
         in_mul   = (c >= 2) && (c <= 1 + m);
         in_shift = (c >= 2 + m) && (rows < DIM);
         is_done  = (c >= 2 + m) && (rows == DIM);
         t = c - 2;
         rdy = ($urandom_range(0, 99) < rdy_pct);
         if (in_shift && rows == stall_at && stalls_left > 0) begin
            rdy = 1'b0;
            stalls_left--;
         end
         outReady = rdy;
         if (noise && c >= 2) start = 1'($urandom_range(0, 1));
         for (int i = 0; i < DIM; i++) e_fv[i] = in_mul && (t >= i) && (t < i + k);
         if (c == rst_c) begin
            #2 reset = 1'b0;
            #1 check_idle("reset_async");
            start = 1'b1;
            outReady = 1'b1;
            repeat (2) @(posedge clock);
            @(negedge clock);
            check_idle("reset_hold");
            reset = 1'b1;
            start = 1'b0;
            @(posedge clock); #1;
            @(negedge clock);
            check_idle("after_reset");
            return;
         end
         @(negedge clock);
         check("ctrl", {busy, peClear, enableMul, enableShiftOut, outValid, done},
               {1'b1, (c == 1), in_mul, in_shift && rdy, in_shift && rdy, is_done});
         check("feedValid", feedValid, e_fv);
         check("feedK", feedK, in_mul ? (LEN_W+1)'(t) : '0);
         check("outRow", outRow, in_shift ? RW'(rows) : '0);
         if (in_shift && rdy) rows++;
         if (is_done) finished = 1'b1;
         @(posedge clock); #1;
         c++;
      end
      start = 1'b0;
      outReady = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_idle("idle_after");
   endtask

   // ---------------- main sequence ----------------
   int mul_cnt, max_fk;
   bit seen;

   initial begin
      reset = 1'b0;
      start = 1'b1;
      kLen = 16'd5;
      outReady = 1'b1;
      s_start = 1'b0;
      s_kLen = 8'd0;
      s_outReady = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle("reset_state");
      reset = 1'b1;

      run_job(3, 100, 0, 0, 0, 0, 0);     // nominal K=3
      run_job(0, 100, 0, 0, 0, 0, 0);     // K=0 skips multiply
      run_job(2, 100, 1, 3, 0, 0, 0);     // 3-cycle stall on row 1
      run_job(4, 100, 0, 0, 1, 0, 0);     // start held through the job
      run_job(5, 70, 2, 2, 0, 1, 0);      // start noise while busy
      run_job(6, 100, 0, 0, 0, 0, 7);     // reset at t=5
      run_job(3, 100, 0, 0, 0, 0, 0);     // full job after reset
      run_job(1, 100, 0, 0, 0, 0, 0);
      for (int j = 0; j < 8; j++) begin
         run_job($urandom_range(0, 9), $urandom_range(40, 100), $urandom_range(0, DIM - 1),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      // Maximum K on a DIM=2, LEN_W=8 instance.
      s_kLen = 8'hFF;
      s_start = 1'b1;
      @(posedge clock); #1;
      s_start = 1'b0;
      mul_cnt = 0;
      max_fk = 0;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (s_mul) mul_cnt++;
         if (int'(s_feedK) > max_fk) max_fk = int'(s_feedK);
         if (s_done) begin
            seen = 1'b1;
            break;
         end
      end
      check("small_done_seen", seen, 1);
      check("small_mul_cycles", mul_cnt, (1 << 8) + 1);
      check("small_feedK_max", max_fk, 1 << 8);

      @(negedge clock);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
